prog_sequencer: RTL and testbench

Parametrised program-counter sequencer for the fetch stage of the processor top level. It replaces the fixed-width PC and the hard-wired `done` compare with a start/done handshake, absolute and relative jumps, and a hardware call/return stack. It also provides stall support and a sticky stack-error flag. It drives `prog_ctr` into the instruction ROM and takes its jump controls from the control decoder and the jump/branch LUTs.

---
 rtl/prog_sequencer_if.sv | 33 +++
 rtl/prog_sequencer.sv | 113 +++++++++++
 tb/tb_prog_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/prog_sequencer_if.sv
// Control/status bundle between the fetch-side controller and prog_sequencer.
// The sequencer sits on the slave modport; the decoder/LUT side drives the master modport.
interface prog_sequencer_if #(
  parameter int D = 12,
  parameter int S = 4
);
  localparam int DW = $clog2(S + 1);

  // Handshake: the master raises req; the sequencer answers with fetch_valid
  // for every cycle whose prog_ctr is executed, then holds done until the next req.
  logic          req;
  logic          stall;
  logic          jump_en;
  logic          jump_rel;
  logic          call;
  logic          ret;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic          fetch_valid;
  logic          done;
  logic          stack_err;
  logic [DW-1:0] depth;

  modport master (
    output req, stall, jump_en, jump_rel, call, ret, target,
    input  prog_ctr, fetch_valid, done, stack_err, depth
  );

  modport slave (
    input  req, stall, jump_en, jump_rel, call, ret, target,
    output prog_ctr, fetch_valid, done, stack_err, depth
  );
endinterface

// File: rtl/prog_sequencer.sv
// Program-counter sequencer: start/done handshake, absolute/relative jumps,
// hardware call/return stack, stall and a sticky stack-error flag.
module prog_sequencer #(
  parameter int D         = 12,
  parameter int S         = 4,
  parameter int HALT_ADDR = 128
) (
  input  logic           clk,
  input  logic           reset,
  prog_sequencer_if.slave bus
);
  localparam int DW = $clog2(S + 1);
  localparam int AW = (S > 1) ? $clog2(S) : 1;
  localparam int SN = 1 << AW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q;
  logic [D-1:0]  pc_q;
  logic [DW-1:0] depth_q;
  logic          err_q;
  logic [D-1:0]  stack_q [0:SN-1];

  logic [D-1:0]  pc_d;
  logic [DW-1:0] depth_d;
  logic          err_d;
  logic          push_d;
  logic          halt_d;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] pop_idx;
  logic          advance;

  assign push_idx = AW'(depth_q);
  assign pop_idx  = AW'(depth_q - DW'(1));
  assign advance  = (state_q == RUN) && !bus.stall;

  // Next PC for an un-stalled RUN cycle; priority ret > call > jump > increment.
  always_comb begin
    pc_d    = pc_q + D'(1);
    depth_d = depth_q;
    err_d   = 1'b0;
    push_d  = 1'b0;
    if (bus.ret) begin
      if (depth_q != '0) begin
        pc_d    = stack_q[pop_idx];
        depth_d = depth_q - DW'(1);
      end else begin
        pc_d  = pc_q;
        err_d = 1'b1;
      end
    end else if (bus.call) begin
      if (depth_q < DW'(S)) begin
        pc_d    = bus.target;
        depth_d = depth_q + DW'(1);
        push_d  = 1'b1;
      end else begin
        pc_d  = pc_q;
        err_d = 1'b1;
      end
    end else if (bus.jump_en) begin
      pc_d = bus.jump_rel ? (pc_q + bus.target) : bus.target;
    end
    halt_d = !err_d && (pc_d == D'(HALT_ADDR));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pc_q <= '0;
          if (bus.req) state_q <= RUN;
        end
        RUN: begin
          if (!bus.stall) begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            if (err_d) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else if (halt_d) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.req) begin
            pc_q    <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stack contents need no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && advance && push_d) stack_q[push_idx] <= pc_q + D'(1);
  end

  assign bus.prog_ctr    = pc_q;
  assign bus.depth       = depth_q;
  assign bus.stack_err   = err_q;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: default D=12 instance plus a D=4 instance
// for PC wrap-around, checked through an expected-value queue.
module tb_prog_sequencer;
  localparam int W = 18;

  logic clk;
  logic reset;

  prog_sequencer_if #(.D(12), .S(4)) ia ();
  prog_sequencer_if #(.D(4),  .S(4)) ib ();

  prog_sequencer #(.D(12), .S(4), .HALT_ADDR(128)) dut_a (
    .clk(clk), .reset(reset), .bus(ia)
  );
  prog_sequencer #(.D(4), .S(4), .HALT_ADDR(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ib)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_a;
  logic [W-1:0] obs_b;
  int n_checks;
  int n_err;

  assign obs_a = {ia.done, ia.fetch_valid, ia.stack_err, ia.depth, ia.prog_ctr};
  assign obs_b = {ib.done, ib.fetch_valid, ib.stack_err, ib.depth, 8'h00, ib.prog_ctr};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input int unsigned pc, input int unsigned dep,
                                      input bit err, input bit fv, input bit dn);
    logic [11:0] p;
    logic [2:0]  d;
    p = 12'(pc);
    d = 3'(dep);
    return {dn, fv, err, d, p};
  endfunction

  task automatic clr();
    ia.req = 0; ia.stall = 0; ia.jump_en = 0; ia.jump_rel = 0;
    ia.call = 0; ia.ret = 0; ia.target = '0;
    ib.req = 0; ib.stall = 0; ib.jump_en = 0; ib.jump_rel = 0;
    ib.call = 0; ib.ret = 0; ib.target = '0;
  endtask

  // Push the expectation, advance one edge, then pop and compare mid-cycle.
  task automatic cyc(input string tag, input logic [W-1:0] exp, input bit sel_b);
    logic [W-1:0] obs;
    logic [W-1:0] e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    obs = sel_b ? obs_b : obs_a;
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    clr();
    reset = 1'b1;
    cyc("reset_a", mk(0, 0, 0, 0, 0), 0);
    cyc("reset_b", mk(0, 0, 0, 0, 0), 1);
    reset = 1'b0;
    cyc("idle_hold", mk(0, 0, 0, 0, 0), 0);

    // default run to HALT_ADDR
    ia.req = 1;
    cyc("start", mk(0, 0, 0, 1, 0), 0);
    ia.req = 0;
    for (int k = 1; k <= 127; k++) cyc("count", mk(k, 0, 0, 1, 0), 0);
    cyc("halt", mk(128, 0, 0, 0, 1), 0);
    ia.stall = 1;
    cyc("done_hold", mk(128, 0, 0, 0, 1), 0);
    ia.stall = 0;

    // call / return / relative jump
    ia.req = 1;
    cyc("restart", mk(0, 0, 0, 1, 0), 0);
    ia.req = 0;
    for (int k = 1; k <= 5; k++) cyc("count_cr", mk(k, 0, 0, 1, 0), 0);
    ia.call = 1; ia.target = 12'd40;
    cyc("call", mk(40, 1, 0, 1, 0), 0);
    clr();
    cyc("after_call", mk(41, 1, 0, 1, 0), 0);
    cyc("after_call", mk(42, 1, 0, 1, 0), 0);
    ia.ret = 1;
    cyc("ret", mk(6, 0, 0, 1, 0), 0);
    clr();
    ia.jump_en = 1; ia.jump_rel = 1; ia.target = 12'hFFE;
    cyc("jump_rel_neg", mk(4, 0, 0, 1, 0), 0);
    clr();

    // underflow
    ia.ret = 1;
    cyc("underflow", mk(4, 0, 1, 0, 1), 0);
    clr();
    ia.call = 1; ia.target = 12'd9;
    cyc("done_ignores_call", mk(4, 0, 1, 0, 1), 0);
    clr();

    // priority: ret wins over call and jump
    ia.req = 1;
    cyc("restart_clears_err", mk(0, 0, 0, 1, 0), 0);
    clr();
    ia.call = 1; ia.target = 12'd100;
    cyc("call_prio", mk(100, 1, 0, 1, 0), 0);
    clr();
    ia.ret = 1; ia.call = 1; ia.jump_en = 1; ia.target = 12'd7;
    cyc("prio_ret", mk(1, 0, 0, 1, 0), 0);
    clr();

    // overflow after four nested calls
    ia.call = 1;
    ia.target = 12'd10; cyc("nest1", mk(10, 1, 0, 1, 0), 0);
    ia.target = 12'd20; cyc("nest2", mk(20, 2, 0, 1, 0), 0);
    ia.target = 12'd30; cyc("nest3", mk(30, 3, 0, 1, 0), 0);
    ia.target = 12'd50; cyc("nest4", mk(50, 4, 0, 1, 0), 0);
    ia.target = 12'd60; cyc("overflow", mk(50, 4, 1, 0, 1), 0);
    clr();
    ia.req = 1;
    cyc("restart_ovf", mk(0, 0, 0, 1, 0), 0);
    clr();

    // stall holds everything, then jump taken
    ia.jump_en = 1; ia.target = 12'd20;
    cyc("jump_abs", mk(20, 0, 0, 1, 0), 0);
    ia.stall = 1; ia.target = 12'd70;
    for (int k = 0; k < 3; k++) cyc("stall", mk(20, 0, 0, 1, 0), 0);
    ia.stall = 0;
    cyc("stall_release", mk(70, 0, 0, 1, 0), 0);
    clr();
    ia.call = 1; ia.target = 12'd50;
    cyc("call_50", mk(50, 1, 0, 1, 0), 0);
    ia.call = 0; ia.jump_en = 1; ia.target = 12'd90;
    reset = 1'b1;
    cyc("reset_mid_run", mk(0, 0, 0, 0, 0), 0);
    reset = 1'b0;
    clr();
    cyc("idle_after_reset", mk(0, 0, 0, 0, 0), 0);

    // D=4 wrap with HALT_ADDR=3
    ib.req = 1;
    cyc("b_start", mk(0, 0, 0, 1, 0), 1);
    clr();
    ib.jump_en = 1; ib.target = 4'd15;
    cyc("b_jump15", mk(15, 0, 0, 1, 0), 1);
    clr();
    cyc("b_wrap0", mk(0, 0, 0, 1, 0), 1);
    cyc("b_wrap1", mk(1, 0, 0, 1, 0), 1);
    cyc("b_wrap2", mk(2, 0, 0, 1, 0), 1);
    cyc("b_halt3", mk(3, 0, 0, 0, 1), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
